// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared constants, types and state encoding for the 8-channel
//               TDM demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    typedef logic [NUM_CH-1:0] chan_t;
    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [0:0]        state_t;

    localparam slot_t c_first_slot = slot_t'(0);
    localparam slot_t c_last_slot  = slot_t'(NUM_CH - 1);

    function automatic logic is_last_slot(input slot_t s);
        return s == c_last_slot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux_8ch_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_8ch_if
// Description : Serial TDM input and parallel channel output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdm_demux_8ch_if;
    import tdm_pkg::*;

    logic  en;
    logic  sync;
    logic  din;
    chan_t y;
    slot_t slot;
    logic  locked;
    logic  frame_valid;
    logic  sync_err;

    modport master (
        output en, sync, din,
        input  y, slot, locked, frame_valid, sync_err
    );

    modport slave (
        input  en, sync, din,
        output y, slot, locked, frame_valid, sync_err
    );

endinterface
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_counter
// Description : Slot index counter with increment, load-to-1 and clear.
//               Priority: clear, then load, then increment (wraps modulo 2^W).
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = SLOT_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_inc,
    input  wire logic             i_load1,
    input  wire logic             i_clr,
    output logic      [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= WIDTH'(1);
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/tdm_demux_8ch.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_8ch
// Description : Receive end of an 8:1 TDM link; aligns on sync and delivers
//               each completed frame in parallel on y.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_8ch
    import tdm_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    tdm_demux_8ch_if.slave     bus
);

    state_t              r_state;
    logic [NUM_CH-2:0]   r_shadow;
    chan_t               r_y;
    logic                r_frame_valid;
    logic                r_sync_err;

    slot_t               w_slot;
    logic                w_cnt_inc;
    logic                w_cnt_load1;
    logic                w_cnt_clr;

    // A sync strobe always restarts at slot 1; an unsynced strobe only
    // advances while running, and at slot 0 it means alignment was lost.
    always_comb begin
        w_cnt_inc   = 1'b0;
        w_cnt_load1 = 1'b0;
        w_cnt_clr   = 1'b0;
        if (bus.en) begin
            if (bus.sync) begin
                w_cnt_load1 = 1'b1;
            end else if (r_state == RUN) begin
                if (w_slot == c_first_slot) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
        end
    end

    tdm_slot_counter #(
        .WIDTH   (SLOT_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_cnt_inc),
        .i_load1 (w_cnt_load1),
        .i_clr   (w_cnt_clr),
        .o_count (w_slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_shadow      <= '0;
            r_y           <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
            if (bus.en) begin
                if (bus.sync) begin
                    // Sync mid-frame abandons the partial frame but keeps lock.
                    r_shadow[0] <= bus.din;
                    r_state     <= RUN;
                    if ((r_state == RUN) && (w_slot != c_first_slot)) begin
                        r_sync_err <= 1'b1;
                    end
                end else if (r_state == RUN) begin
                    if (w_slot == c_first_slot) begin
                        r_sync_err <= 1'b1;
                        r_state    <= HUNT;
                    end else if (is_last_slot(w_slot)) begin
                        r_y           <= {bus.din, r_shadow};
                        r_frame_valid <= 1'b1;
                    end else begin
                        r_shadow[w_slot] <= bus.din;
                    end
                end
            end
        end
    end

    assign bus.y           = r_y;
    assign bus.slot        = w_slot;
    assign bus.locked      = r_state;
    assign bus.frame_valid = r_frame_valid;
    assign bus.sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_8ch.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux_8ch
// Description : Directed self-checking bench for tdm_demux_8ch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_8ch;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tdm_demux_8ch_if bus();

    tdm_demux_8ch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit run_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame model: a locked receiver collects bits into a list; list length is the slot.
    logic       m_locked = 1'b0;
    logic       m_q[$];
    logic [7:0] m_y      = 8'h00;
    logic       m_fv     = 1'b0;
    logic       m_err    = 1'b0;

    task automatic model_reset();
        m_locked = 1'b0;
        m_q.delete();
        m_y   = 8'h00;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic s, input logic d);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (e) begin
            if (s) begin
                m_err    = m_locked && (m_q.size() != 0);
                m_locked = 1'b1;
                m_q.delete();
                m_q.push_back(d);
            end else if (m_locked) begin
                if (m_q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_q.push_back(d);
                    if (m_q.size() == 8) begin
                        for (int k = 0; k < 8; k++) m_y[k] = m_q[k];
                        m_fv = 1'b1;
                        m_q.delete();
                    end
                end
            end
        end
    endtask

    int fv_cnt  = 0;
    int err_cnt = 0;
    int fv_cyc[$];
    logic [7:0] fv_val[$];

    always @(negedge clk) begin
        if (run_chk) begin
            chk("y",           32'(bus.y),           32'(m_y));
            chk("slot",        32'(bus.slot),        32'(m_q.size()));
            chk("locked",      32'(bus.locked),      32'(m_locked));
            chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
            chk("sync_err",    32'(bus.sync_err),    32'(m_err));
            chk("pulse_excl",  32'(bus.frame_valid & bus.sync_err), 32'd0);
            if (bus.frame_valid === 1'b1) begin
                fv_cnt++;
                fv_cyc.push_back(cyc);
                fv_val.push_back(bus.y);
            end
            if (bus.sync_err === 1'b1) err_cnt++;
        end
    end

    task automatic strobe(input logic e, input logic s, input logic d);
        @(negedge clk);
        bus.en   = e;
        bus.sync = s;
        bus.din  = d;
        @(posedge clk);
        #1;
        model_step(e, s, d);
    endtask

    task automatic idle(input int n);
        repeat (n) strobe(1'b0, 1'b0, 1'b0);
    endtask

    int start_cyc;

    task automatic send_frame(input logic [7:0] v, input int gap_after, input int gap_len);
        for (int k = 0; k < 8; k++) begin
            strobe(1'b1, k == 0, v[k]);
            if (k == 0) start_cyc = cyc;
            if (k == gap_after) idle(gap_len);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int fv0, err0;
        logic [7:0] v52;
        v52 = 8'h52;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.din  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y",      32'(bus.y), 32'h00);
        chk("rst_slot",   32'(bus.slot), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_fv",     32'(bus.frame_valid), 32'd0);
        chk("rst_err",    32'(bus.sync_err), 32'd0);
        run_chk = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame 1,0,1,1,0,1,0,1 -> 8'hAD
        idle(2);
        send_frame(8'hAD, -1, 0);
        chk("f1_y",      32'(bus.y), 32'hAD);
        chk("f1_fv",     32'(bus.frame_valid), 32'd1);
        chk("f1_locked", 32'(bus.locked), 32'd1);
        chk("f1_slot",   32'(bus.slot), 32'd0);
        idle(1);
        chk("f1_lat",    32'(fv_cyc[$] - start_cyc), 32'd7);
        chk("f1_count",  32'(fv_cnt), 32'd1);

        // Back-to-back frames
        fv_cyc.delete();
        fv_val.delete();
        err0 = err_cnt;
        send_frame(8'hAD, -1, 0);
        send_frame(8'h52, -1, 0);
        idle(2);
        chk("b2b_n",     32'(fv_cyc.size()), 32'd2);
        chk("b2b_gap",   32'(fv_cyc[1] - fv_cyc[0]), 32'd8);
        chk("b2b_v0",    32'(fv_val[0]), 32'hAD);
        chk("b2b_v1",    32'(fv_val[1]), 32'h52);
        chk("b2b_err",   32'(err_cnt - err0), 32'd0);

        // en gap of 3 after slot 3
        send_frame(8'hAD, 3, 3);
        idle(1);
        chk("gap_lat",   32'(fv_cyc[$] - start_cyc), 32'd10);
        chk("gap_y",     32'(bus.y), 32'hAD);

        // Sync at slot 4 restarts the frame
        fv0 = fv_cnt;
        strobe(1'b1, 1'b1, 1'b1);
        repeat (3) strobe(1'b1, 1'b0, 1'b1);
        strobe(1'b1, 1'b1, v52[0]);
        chk("s4_err",    32'(bus.sync_err), 32'd1);
        chk("s4_y",      32'(bus.y), 32'hAD);
        chk("s4_slot",   32'(bus.slot), 32'd1);
        chk("s4_locked", 32'(bus.locked), 32'd1);
        for (int k = 1; k < 8; k++) strobe(1'b1, 1'b0, v52[k]);
        chk("s4_fv",     32'(bus.frame_valid), 32'd1);
        chk("s4_newy",   32'(bus.y), 32'h52);
        idle(1);
        chk("s4_fvcnt",  32'(fv_cnt - fv0), 32'd1);

        // Missing sync at slot 0 drops lock
        err0 = err_cnt;
        strobe(1'b1, 1'b0, 1'b1);
        chk("ms_err",    32'(bus.sync_err), 32'd1);
        chk("ms_locked", 32'(bus.locked), 32'd0);
        for (int k = 0; k < 5; k++) strobe(1'b1, 1'b0, k[0]);
        chk("ms_slot",   32'(bus.slot), 32'd0);
        chk("ms_hold",   32'(bus.locked), 32'd0);
        chk("ms_y",      32'(bus.y), 32'h52);
        chk("ms_errcnt", 32'(err_cnt - err0), 32'd1);

        // Asynchronous reset mid-frame at slot 5
        fv0  = fv_cnt;
        err0 = err_cnt;
        strobe(1'b1, 1'b1, 1'b1);
        repeat (4) strobe(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_y",      32'(bus.y), 32'h00);
        chk("ar_slot",   32'(bus.slot), 32'd0);
        chk("ar_locked", 32'(bus.locked), 32'd0);
        chk("ar_fv",     32'(bus.frame_valid), 32'd0);
        chk("ar_err",    32'(bus.sync_err), 32'd0);
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'hFF, -1, 0);
        chk("ar_ffy",    32'(bus.y), 32'hFF);
        idle(2);
        chk("ar_pulses", 32'(fv_cnt - fv0), 32'd1);
        chk("ar_errs",   32'(err_cnt - err0), 32'd0);

        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
